// File: rtl/alu_ctrl_skid.sv
// ALU control decode feeding a two-entry skid buffer (main + skid) between ID and EX.
// Optional feature: define ALU_ILLEGAL_CNT_EN to build the saturating illegal-op counter.
module alu_ctrl_skid #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       sell,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal,
    output logic [7:0]       illegal_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [3:0]       sell;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } op_t;

    state_t state, state_nxt;
    op_t    main_q, skid_q, dec;
    logic   rdy_q;
    logic   accept, xfer;
    logic   ld_main, ld_skid, main_from_skid;

    // Decode on the input side so each buffer entry already holds the final select.
    always_comb begin
        dec.tag     = in_tag;
        dec.sell    = 4'b1111;
        dec.illegal = 1'b1;
        case (alu_op)
            2'b00: begin dec.sell = 4'b0010; dec.illegal = 1'b0; end
            2'b01: begin dec.sell = 4'b0110; dec.illegal = 1'b0; end
            default: begin
                case (funct3)
                    3'b000: begin
                        dec.sell    = (alu_op == 2'b10 && funct7_5) ? 4'b0110 : 4'b0010;
                        dec.illegal = 1'b0;
                    end
                    3'b111: begin dec.sell = 4'b0000; dec.illegal = 1'b0; end
                    3'b110: begin dec.sell = 4'b0001; dec.illegal = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

    assign out_valid = (state != EMPTY);
    assign in_ready  = rdy_q;
    assign accept    = in_valid && rdy_q;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        ld_main        = 1'b0;
        ld_skid        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                ld_main   = 1'b1;
            end
            ONE: begin
                case ({accept, xfer})
                    2'b10: begin state_nxt = FULL; ld_skid = 1'b1; end
                    2'b01: state_nxt = EMPTY;
                    2'b11: ld_main = 1'b1;
                    default: ;
                endcase
            end
            FULL: if (xfer) begin
                state_nxt      = ONE;
                main_from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops both entries and any op accepted this same cycle.
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            rdy_q  <= 1'b1;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != FULL);
            if (ld_main)             main_q <= dec;
            else if (main_from_skid) main_q <= skid_q;
            if (ld_skid)             skid_q <= dec;
        end
    end

    assign sell    = out_valid ? main_q.sell    : 4'b0000;
    assign out_tag = out_valid ? main_q.tag     : '0;
    assign illegal = out_valid ? main_q.illegal : 1'b0;

`ifdef ALU_ILLEGAL_CNT_EN
    logic [7:0] cnt_q;

    // Counts at accept time, so ops discarded later by flush are still counted.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= 8'd0;
        else if (accept && dec.illegal && cnt_q != 8'hff)
            cnt_q <= cnt_q + 8'd1;
    end

    assign illegal_cnt = cnt_q;
`else
    assign illegal_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_ctrl_skid.sv
// Scoreboard bench for alu_ctrl_skid: expected ops queued at accept, checked at the EX side.
module tb_alu_ctrl_skid;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = 2'b00;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic [4:0] in_tag = 5'd0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] sell;
    logic [4:0] out_tag;
    logic       illegal;
    logic [7:0] illegal_cnt;

    alu_ctrl_skid #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .sell(sell), .out_tag(out_tag), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sell;
        logic [4:0] tag;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    function automatic exp_t model(logic [1:0] op, logic [2:0] f3, logic f7, logic [4:0] tag);
        exp_t m;
        m.tag  = tag;
        m.sell = 4'b1111;
        m.ill  = 1'b1;
        if (op == 2'b00)           begin m.sell = 4'b0010; m.ill = 1'b0; end
        else if (op == 2'b01)      begin m.sell = 4'b0110; m.ill = 1'b0; end
        else if (f3 == 3'b111)     begin m.sell = 4'b0000; m.ill = 1'b0; end
        else if (f3 == 3'b110)     begin m.sell = 4'b0001; m.ill = 1'b0; end
        else if (f3 == 3'b000) begin
            m.sell = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
            m.ill  = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [7:0] cnt_req();
`ifdef ALU_ILLEGAL_CNT_EN
        return exp_cnt[7:0];
`else
        return 8'd0;
`endif
    endfunction

    // EX-side scoreboard: presented op must match the oldest outstanding accept.
    always @(negedge clk) begin
        if (rst) begin
            n_chk++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got op tag=%0d sell=%b, required no op", out_tag, sell);
                end else begin
                    if ({sell, out_tag, illegal} !== {q[0].sell, q[0].tag, q[0].ill}) begin
                        n_fail++;
                        $display("FAIL sb_op: got sell=%b tag=%0d ill=%b, required sell=%b tag=%0d ill=%b",
                                 sell, out_tag, illegal, q[0].sell, q[0].tag, q[0].ill);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end else if ({sell, out_tag, illegal} !== 10'd0) begin
                n_fail++;
                $display("FAIL idle_zero: got sell=%b tag=%0d ill=%b, required zeros", sell, out_tag, illegal);
            end
        end
    end

    task automatic set_op(input logic v, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, input logic [4:0] tag);
        in_valid = v; alu_op = op; funct3 = f3; funct7_5 = f7; in_tag = tag;
    endtask

    task automatic step();
        logic r, f, acc;
        exp_t m;
        r = rst; f = flush; acc = in_valid && in_ready;
        m = model(alu_op, funct3, funct7_5, in_tag);
        if (r && acc) begin
            if (!f) q.push_back(m);
            if (m.ill && exp_cnt != 255) exp_cnt++;
        end
        @(posedge clk); #1;
        if (!r) begin q.delete(); exp_cnt = 0; end
        else if (f) q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step(); step();
        n_chk++;
        if ({out_valid, in_ready, sell, out_tag, illegal, illegal_cnt} !== {1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_vals: got ov=%b ir=%b sell=%b tag=%0d ill=%b cnt=%0d, required 0 1 0000 0 0 0",
                     out_valid, in_ready, sell, out_tag, illegal, illegal_cnt);
        end
        in_valid = 1'b0; rst = 1'b1;
        step();
    endtask

    task automatic test_sub_latency();
        out_ready = 1'b1;
        set_op(1'b1, 2'b10, 3'b000, 1'b1, 5'd7);
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({out_valid, sell, out_tag} !== {1'b1, 4'b0110, 5'd7}) begin
            n_fail++;
            $display("FAIL sub_latency: got ov=%b sell=%b tag=%0d, required 1 0110 7", out_valid, sell, out_tag);
        end
        step(); step();
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++)
            begin set_op(1'b1, i[5:4], i[3:1], i[0], i[4:0]); step(); end
        in_valid = 1'b0;
        step(); step();
        n_chk++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL decode_drain: got %0d ops outstanding, required 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_op(1'b1, 2'b10, 3'b000, 1'b0, 5'd1); step();
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b, required 1", in_ready); end
        set_op(1'b1, 2'b10, 3'b111, 1'b0, 5'd2); step();
        set_op(1'b1, 2'b11, 3'b110, 1'b0, 5'd3); step(); step();
        n_chk++;
        if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL b2b_full: got ir=%b ov=%b tag=%0d, required 0 1 1", in_ready, out_valid, out_tag);
        end
        out_ready = 1'b1; step();
        n_chk++;
        if ({in_ready, out_tag} !== {1'b1, 5'd2}) begin
            n_fail++;
            $display("FAIL b2b_skid: got ir=%b tag=%0d, required 1 2", in_ready, out_tag);
        end
        step();
        in_valid = 1'b0;
        step(); step();
        n_chk++;
        if (out_valid !== 1'b0 || q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got ov=%b outstanding=%0d, required 0 0", out_valid, q.size());
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_op(1'b1, 2'b00, 3'b000, 1'b0, 5'd10); step();
        set_op(1'b1, 2'b11, 3'b010, 1'b0, 5'd11); step();
        set_op(1'b1, 2'b01, 3'b000, 1'b0, 5'd12); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        n_chk++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_full: got ov=%b ir=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1; step(); step();
        out_ready = 1'b0;
        set_op(1'b1, 2'b00, 3'b000, 1'b0, 5'd13); step();
        set_op(1'b1, 2'b10, 3'b011, 1'b1, 5'd14); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        n_chk++;
        if ({out_valid, in_ready} !== 2'b01 || illegal_cnt !== cnt_req()) begin
            n_fail++;
            $display("FAIL flush_one: got ov=%b ir=%b cnt=%0d, required 0 1 %0d",
                     out_valid, in_ready, illegal_cnt, cnt_req());
        end
        out_ready = 1'b1; step(); step();
    endtask

    task automatic test_illegal_cnt();
        rst = 1'b0; step(); rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_op(1'b1, 2'b11, 3'b001, 1'b0, i[4:0]);
            step();
            if (i == 0) begin
                n_chk++;
                if ({illegal, sell} !== {1'b1, 4'b1111}) begin
                    n_fail++;
                    $display("FAIL illegal_out: got ill=%b sell=%b, required 1 1111", illegal, sell);
                end
            end
            if (i == 9) begin
                n_chk++;
                if (illegal_cnt !== cnt_req()) begin
                    n_fail++;
                    $display("FAIL cnt_mid: got %0d, required %0d", illegal_cnt, cnt_req());
                end
            end
        end
        in_valid = 1'b0; step(); step();
        n_chk++;
`ifdef ALU_ILLEGAL_CNT_EN
        if (illegal_cnt !== 8'd255) begin
            n_fail++; $display("FAIL cnt_sat: got %0d, required 255", illegal_cnt);
        end
`else
        if (illegal_cnt !== 8'd0) begin
            n_fail++; $display("FAIL cnt_off: got %0d, required 0", illegal_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_op(1'b1, 2'b11, 3'b100, 1'b0, 5'd20); step();
        set_op(1'b1, 2'b10, 3'b110, 1'b0, 5'd21); step();
        in_valid = 1'b0;
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got ir=%b, required 0", in_ready); end
        out_ready = 1'b1; rst = 1'b0; step();
        n_chk++;
        if ({out_valid, in_ready, sell, out_tag, illegal, illegal_cnt} !== {1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rmid_vals: got ov=%b ir=%b sell=%b tag=%0d ill=%b cnt=%0d, required 0 1 0000 0 0 0",
                     out_valid, in_ready, sell, out_tag, illegal, illegal_cnt);
        end
        rst = 1'b1; step(); step();
    endtask

    initial begin
        test_reset();
        test_sub_latency();
        test_decode();
        test_back_to_back();
        test_flush();
        test_illegal_cnt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
